// File: rtl/chs_actuator_ctrl_pkg.sv
// chs_actuator_ctrl_pkg: shared FSM state encoding, level/frame constants and target clamp
package chs_actuator_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RAMP, HOLD, DEAD} state_e;
  localparam logic [3:0] MAX_LEVEL = 4'd8;
  localparam int PWM_FRAME = 8;
  function automatic logic [3:0] clamp_level(input logic [3:0] p);
    return p > MAX_LEVEL ? MAX_LEVEL : p;
  endfunction
endpackage

// File: rtl/chs_actuator_ctrl_pwm_gen.sv
// chs_pwm_gen: free-running PWM frame counter with level compare
//   clk, rst : clock, synchronous active-high reset
//   level    : duty in frame slots, 0 = always low, PWM_FRAME = always high
//   drive    : high while the frame position is below level
module chs_pwm_gen
  import chs_actuator_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] level,
  output logic       drive
);
  localparam int FW = $clog2(PWM_FRAME);
  logic [FW-1:0] frame_q;
  always_ff @(posedge clk)
    frame_q <= (rst || frame_q == FW'(PWM_FRAME - 1)) ? '0 : frame_q + FW'(1);
  assign drive = 4'(frame_q) < level;
endmodule

// File: rtl/chs_actuator_ctrl.sv
// chs_actuator_ctrl: ramped heater/cooler PWM driver with drain and dead time on mode reversal
//   clk, rst            : clock, synchronous active-high reset
//   chs_valid           : strobe capturing chs_power (clamped to 8) and chs_mode as the new target
//   heat_pwm, cool_pwm  : actuator drives, never both high
//   act_level, act_mode : applied level 0..8 and the mode owning the actuators
//   busy                : high while ramping or in dead time
module chs_actuator_ctrl
  import chs_actuator_ctrl_pkg::*;
#(
  parameter int RAMP_DIV = 4,
  parameter int DEAD_CYC = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       chs_valid,
  input  logic [3:0] chs_power,
  input  logic       chs_mode,
  output logic       heat_pwm,
  output logic       cool_pwm,
  output logic [3:0] act_level,
  output logic       act_mode,
  output logic       busy
);
  localparam int RW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
  localparam int DW = DEAD_CYC > 1 ? $clog2(DEAD_CYC) : 1;
  state_e state_q, state_d;
  logic [3:0] lvl_q, lvl_d, tgt_lvl_q, eff;
  logic mode_q, mode_d, tgt_mode_q, rev, drive, ramp_wrap;
  logic [RW-1:0] ramp_q, ramp_d;
  logic [DW-1:0] dead_q, dead_d;
  // a target in the other mode is ramped toward zero first; rev asks for the switch-over
  assign eff = tgt_mode_q == mode_q ? tgt_lvl_q : 4'd0;
  assign rev = tgt_mode_q != mode_q && tgt_lvl_q != 4'd0;
  assign ramp_wrap = ramp_q == RW'(RAMP_DIV - 1);
  always_comb begin
    state_d = state_q;
    lvl_d = lvl_q;
    mode_d = mode_q;
    ramp_d = ramp_wrap ? '0 : ramp_q + RW'(1);
    dead_d = dead_q + DW'(1);
    case (state_q)
      IDLE: begin
        state_d = rev ? DEAD : eff != 4'd0 ? RAMP : IDLE;
        ramp_d = '0;
        dead_d = '0;
      end
      RAMP: begin
        if (lvl_q == eff) begin
          state_d = eff != 4'd0 ? HOLD : rev ? DEAD : IDLE;
          dead_d = '0;
        end else if (ramp_wrap) begin
          lvl_d = lvl_q < eff ? lvl_q + 4'd1 : lvl_q - 4'd1;
        end
      end
      HOLD: begin
        state_d = eff != lvl_q ? RAMP : HOLD;
        ramp_d = '0;
      end
      DEAD: begin
        if (dead_q == DW'(DEAD_CYC - 1)) begin
          mode_d = tgt_mode_q;
          state_d = tgt_lvl_q == 4'd0 ? IDLE : RAMP;
          ramp_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lvl_q <= 4'd0;
      mode_q <= 1'b0;
      tgt_lvl_q <= 4'd0;
      tgt_mode_q <= 1'b0;
      ramp_q <= '0;
      dead_q <= '0;
    end else begin
      state_q <= state_d;
      lvl_q <= lvl_d;
      mode_q <= mode_d;
      ramp_q <= ramp_d;
      dead_q <= dead_d;
      if (chs_valid) begin
        tgt_lvl_q <= clamp_level(chs_power);
        tgt_mode_q <= chs_mode;
      end
    end
  end
  chs_pwm_gen u_pwm (
    .clk  (clk),
    .rst  (rst),
    .level(lvl_q),
    .drive(drive)
  );
  assign act_level = lvl_q;
  assign act_mode = mode_q;
  assign busy = state_q == RAMP || state_q == DEAD;
  assign heat_pwm = drive & mode_q & (state_q != DEAD);
  assign cool_pwm = drive & ~mode_q & (state_q != DEAD);
  assert property (@(posedge clk) !(heat_pwm && cool_pwm));
endmodule

// File: tb/tb_chs_actuator_ctrl.sv
// tb_chs_actuator_ctrl: directed and random stimulus against a cycle-level behavioural model
module tb_chs_actuator_ctrl;
  localparam int RD = 4;
  localparam int DC = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chs_valid = 1'b0;
  logic [3:0] chs_power = 4'd0;
  logic chs_mode = 1'b0;
  logic heat_pwm, cool_pwm, act_mode, busy;
  logic [3:0] act_level;
  int checks = 0;
  int errors = 0;
  int m_lvl = 0, m_mode = 0, t_lvl = 0, t_mode = 0, frame = 0, ramp_left = 0, dead_left = 0;
  string ph = "IDLE";
  string scen = "init";

  chs_actuator_ctrl #(.RAMP_DIV(RD), .DEAD_CYC(DC)) dut (
    .clk(clk), .rst(rst), .chs_valid(chs_valid), .chs_power(chs_power), .chs_mode(chs_mode),
    .heat_pwm(heat_pwm), .cool_pwm(cool_pwm), .act_level(act_level), .act_mode(act_mode), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one clock edge of the behavioural model; v/p/m/r are the inputs present at that edge
  task automatic model(input logic v, input logic [3:0] p, input logic m, input logic r);
    int eff;
    bit rev;
    eff = (t_mode == m_mode) ? t_lvl : 0;
    rev = (t_mode != m_mode) && (t_lvl > 0);
    if (ph == "IDLE") begin
      if (rev) begin ph = "DEAD"; dead_left = DC; end
      else if (eff > 0) begin ph = "RAMP"; ramp_left = RD; end
    end else if (ph == "RAMP") begin
      if (m_lvl == eff) begin
        if (eff > 0) ph = "HOLD";
        else if (rev) begin ph = "DEAD"; dead_left = DC; end
        else ph = "IDLE";
      end else begin
        ramp_left -= 1;
        if (ramp_left == 0) begin
          m_lvl += (m_lvl < eff) ? 1 : -1;
          ramp_left = RD;
        end
      end
    end else if (ph == "HOLD") begin
      if (eff != m_lvl) begin ph = "RAMP"; ramp_left = RD; end
    end else begin
      dead_left -= 1;
      if (dead_left == 0) begin
        m_mode = t_mode;
        ph = (t_lvl == 0) ? "IDLE" : "RAMP";
        ramp_left = RD;
      end
    end
    frame = (frame + 1) % 8;
    if (v) begin
      t_lvl = (int'(p) > 8) ? 8 : int'(p);
      t_mode = int'(m);
    end
    if (r) begin
      m_lvl = 0; m_mode = 0; t_lvl = 0; t_mode = 0; frame = 0; ph = "IDLE";
    end
  endtask

  task automatic check_all();
    bit on;
    on = (frame < m_lvl) && (ph != "DEAD");
    chk({scen, ":level"}, 8'(act_level), 8'(m_lvl));
    chk({scen, ":mode"}, 8'(act_mode), 8'(m_mode));
    chk({scen, ":busy"}, 8'(busy), 8'(ph == "RAMP" || ph == "DEAD"));
    chk({scen, ":heat"}, 8'(heat_pwm), 8'(on && m_mode == 1));
    chk({scen, ":cool"}, 8'(cool_pwm), 8'(on && m_mode == 0));
  endtask

  task automatic cyc(input logic v = 1'b0, input logic [3:0] p = 4'd0, input logic m = 1'b0,
                     input logic r = 1'b0);
    chs_valid = v; chs_power = p; chs_mode = m; rst = r;
    @(posedge clk);
    model(v, p, m, r);
    #1 check_all();
  endtask

  initial begin
    int hc, cc, mx;
    scen = "reset";
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("rst_level", 8'(act_level), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_pwm", 8'({heat_pwm, cool_pwm}), 8'd0);

    scen = "cool4";
    cyc(1, 4, 0);
    repeat (17) cyc();
    chk("cool4_level", 8'(act_level), 8'd4);
    chk("cool4_busy_ramp", 8'(busy), 8'd1);
    cyc();
    chk("cool4_busy_hold", 8'(busy), 8'd0);
    hc = 0; cc = 0;
    repeat (8) begin cyc(); hc += int'(heat_pwm); cc += int'(cool_pwm); end
    chk("cool4_duty", 8'(cc), 8'd4);
    chk("cool4_heat", 8'(hc), 8'd0);

    scen = "heat2";
    cyc(1, 2, 1);
    repeat (40) cyc();
    chk("heat2_mode", 8'(act_mode), 8'd1);
    chk("heat2_level", 8'(act_level), 8'd2);
    hc = 0; cc = 0;
    repeat (8) begin cyc(); hc += int'(heat_pwm); cc += int'(cool_pwm); end
    chk("heat2_duty", 8'(hc), 8'd2);
    chk("heat2_cool", 8'(cc), 8'd0);

    scen = "clamp";
    cyc(1, 12, 0);
    repeat (70) cyc();
    chk("clamp_level", 8'(act_level), 8'd8);
    cc = 0;
    repeat (8) begin cyc(); cc += int'(cool_pwm); end
    chk("clamp_duty", 8'(cc), 8'd8);

    scen = "retgt";
    cyc(0, 0, 0, 1);
    cyc(1, 6, 0);
    for (int i = 0; i < 40 && act_level != 4'd3; i++) cyc();
    chk("retgt_reach3", 8'(act_level), 8'd3);
    cyc(1, 1, 0);
    mx = 0;
    repeat (20) begin cyc(); if (int'(act_level) > mx) mx = int'(act_level); end
    chk("retgt_max", 8'(mx), 8'd3);
    chk("retgt_level", 8'(act_level), 8'd1);

    scen = "drain";
    cyc(1, 5, 0);
    repeat (30) cyc();
    chk("drain_hold5", 8'(act_level), 8'd5);
    cyc(1, 0, 0);
    repeat (30) cyc();
    chk("drain_level", 8'(act_level), 8'd0);
    chk("drain_busy", 8'(busy), 8'd0);
    chk("drain_pwm", 8'({heat_pwm, cool_pwm}), 8'd0);

    scen = "rst_dead";
    cyc(1, 5, 0);
    repeat (30) cyc();
    cyc(1, 3, 1);
    for (int i = 0; i < 60 && ph != "DEAD"; i++) cyc();
    repeat (3) cyc();
    chk("rst_dead_busy", 8'(busy), 8'd1);
    cyc(0, 0, 0, 1);
    chk("rst_dead_out", 8'({heat_pwm, cool_pwm, busy, act_mode, act_level}), 8'd0);

    scen = "rst_ramp";
    cyc(1, 7, 0);
    repeat (10) cyc();
    chk("rst_ramp_busy", 8'(busy), 8'd1);
    cyc(0, 0, 0, 1);
    chk("rst_ramp_out", 8'({heat_pwm, cool_pwm, busy, act_mode, act_level}), 8'd0);
    cyc(1, 2, 1);
    repeat (40) cyc();
    chk("restart_mode", 8'(act_mode), 8'd1);
    chk("restart_level", 8'(act_level), 8'd2);

    scen = "random";
    repeat (800)
      cyc(1'($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 299) == 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
